// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer.
//   cmd_e   : command encodings presented on alu_seq_ctrl.cmd
//   ALUOP_* : operation select driven onto the ALU op input
//   state_e : sequencer FSM state encoding
package alu_pkg;

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_AND = 3'd2,
    CMD_OR  = 3'd3,
    CMD_MUL = 3'd4,
    CMD_ACC = 3'd5,
    CMD_CLR = 3'd6,
    CMD_ILL = 3'd7
  } cmd_e;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_AND = 2'b10;
  localparam logic [1:0] ALUOP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU.
//   a, b : operands
//   op   : 00 add, 01 sub, 10 and, 11 or
//   res  : 4-bit result
//   cout : carry out for add; for sub it is the carry of a + ~b + 1,
//          so 1 means no borrow. Forced to 0 for the logic ops.
module alu
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] res,
  output logic       cout
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + 5'd1;

  always_comb begin
    res  = 4'd0;
    cout = 1'b0;
    case (op)
      ALUOP_ADD: begin res = sum[3:0];  cout = sum[4];  end
      ALUOP_SUB: begin res = diff[3:0]; cout = diff[4]; end
      ALUOP_AND: res = a & b;
      default:   res = a | b;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around an external combinational 4-bit ALU.
// Accepts commands over cmd_valid/cmd_ready, runs them through the ALU
// (single-cycle ops, 4-step shift-add multiply, 4-bit accumulator) and
// returns results over rsp_valid/rsp_ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready : command handshake; cmd, a, b sampled on accept
//   alu_a/alu_b/alu_op  : operands and op driven to the ALU
//   alu_res/alu_cout    : ALU result and carry
//   rsp_valid/rsp_ready : response handshake
//   result/carry/err    : response payload, held stable while rsp_valid
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] result,
  output logic       carry,
  output logic       err
);

  state_e     state, state_next;
  logic [2:0] cmd_q;
  logic [3:0] a_q, b_q;
  logic [3:0] acc;
  logic [3:0] p_hi, q;
  logic [1:0] step;
  logic       accept;
  logic [3:0] p_hi_next, q_next;

  assign accept = cmd_valid & cmd_ready;

  // One shift-add multiply step: when the multiplier LSB is set the partial
  // product P_hi + a (with carry) is shifted right together with Q,
  // otherwise P_hi alone is shifted into Q.
  always_comb begin
    if (q[0]) begin
      p_hi_next = {alu_cout, alu_res[3:1]};
      q_next    = {alu_res[0], q[3:1]};
    end else begin
      p_hi_next = {1'b0, p_hi[3:1]};
      q_next    = {p_hi[0], q[3:1]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_ACC: state_next = ST_EXEC;
            CMD_MUL: state_next = ST_MUL;
            default: state_next = ST_DONE;
          endcase
        end
      end
      ST_EXEC: state_next = ST_DONE;
      ST_MUL:  if (step == 2'd3) state_next = ST_DONE;
      default: if (rsp_ready) state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_DONE);
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    alu_op    = ALUOP_ADD;
    case (state)
      ST_EXEC: begin
        alu_a  = (cmd_q == CMD_ACC) ? acc : a_q;
        alu_b  = b_q;
        alu_op = (cmd_q == CMD_ACC) ? ALUOP_ADD : cmd_q[1:0];
      end
      ST_MUL: begin
        alu_a  = p_hi;
        alu_b  = a_q;
        alu_op = ALUOP_ADD;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q  <= 3'd0;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      acc    <= 4'd0;
      p_hi   <= 4'd0;
      q      <= 4'd0;
      step   <= 2'd0;
      result <= 8'd0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q <= cmd;
            a_q   <= a;
            b_q   <= b;
            p_hi  <= 4'd0;
            q     <= b;
            step  <= 2'd0;
            if (cmd == CMD_CLR) begin
              acc    <= 4'd0;
              result <= 8'd0;
              carry  <= 1'b0;
              err    <= 1'b0;
            end else if (cmd == CMD_ILL) begin
              result <= 8'd0;
              carry  <= 1'b0;
              err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          result <= {4'd0, alu_res};
          // Carry is only meaningful for the arithmetic ops
          carry  <= (cmd_q == CMD_ADD || cmd_q == CMD_SUB || cmd_q == CMD_ACC)
                    ? alu_cout : 1'b0;
          if (cmd_q == CMD_ACC) acc <= alu_res;
        end
        ST_MUL: begin
          p_hi <= p_hi_next;
          q    <= q_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            result <= {p_hi_next, q_next};
            carry  <= 1'b0;
          end
        end
        default: begin
          if (rsp_ready) err <= 1'b0;
        end
      endcase
    end
  end

endmodule
